add_req_sequencer: RTL and testbench

- Initiator-side companion for the team's start/valid two-operand adder datapath.
- Buffers operand pairs arriving on a valid/ready stream and issues them to the adder as single-cycle `add_start` pulses.
- Tracks in-flight requests, captures returned results into a result FIFO and presents them downstream on valid/ready.
- Credit throttling ensures a returned result is never dropped.

---
 rtl/add_req_sequencer.sv | 128 ++++++++++++
 tb/tb_add_req_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_req_sequencer.sv
// Initiator-side sequencer for the start/valid adder: buffers operand pairs, issues
// single-cycle add_start pulses under result-FIFO credit, and returns results in order.
module add_req_sequencer #(
   parameter int W      = 12,
   parameter int CDEPTH = 4,
   parameter int RDEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         add_start,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   input  logic [W-1:0] add_y,
   input  logic         add_valid,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_y,
   output logic         busy,
   output logic         err_unexp
);

   localparam int CAW = $clog2(CDEPTH);
   localparam int RAW = $clog2(RDEPTH);

   logic [W-1:0]   cmd_a_mem [CDEPTH];
   logic [W-1:0]   cmd_b_mem [CDEPTH];
   logic [CAW-1:0] cmd_wp;
   logic [CAW-1:0] cmd_rp;
   logic [CAW:0]   cmd_count;

   logic [W-1:0]   res_mem [RDEPTH];
   logic [RAW-1:0] res_wp;
   logic [RAW-1:0] res_rp;
   logic [RAW:0]   res_count;
   logic [RAW:0]   outstanding;

   logic [RAW+1:0] credit_used;
   logic           cmd_push;
   logic           issue;
   logic           res_accept;
   logic           res_pop;
   logic           unexp;

   // Credit counts both in-flight requests and results still buffered, so every
   // legal return always finds a free result slot.
   assign credit_used = {1'b0, outstanding} + {1'b0, res_count};

   assign in_ready   = (cmd_count < (CAW+1)'(CDEPTH));
   assign cmd_push   = in_valid & in_ready;
   assign issue      = (cmd_count != '0) && (credit_used < (RAW+2)'(RDEPTH));
   assign res_accept = add_valid && (outstanding != '0);
   assign unexp      = add_valid && (outstanding == '0) && !issue;
   assign out_valid  = (res_count != '0);
   assign out_y      = res_mem[res_rp];
   assign res_pop    = out_valid & out_ready;
   assign busy       = (cmd_count != '0) | (outstanding != '0) | (res_count != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CDEPTH; i++) begin
            cmd_a_mem[i] <= '0;
            cmd_b_mem[i] <= '0;
         end
         cmd_wp    <= '0;
         cmd_rp    <= '0;
         cmd_count <= '0;
         add_start <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
      end else begin
         if (cmd_push) begin
            cmd_a_mem[cmd_wp] <= in_a;
            cmd_b_mem[cmd_wp] <= in_b;
            cmd_wp            <= cmd_wp + 1'b1;
         end
         add_start <= issue;
         if (issue) begin
            add_a  <= cmd_a_mem[cmd_rp];
            add_b  <= cmd_b_mem[cmd_rp];
            cmd_rp <= cmd_rp + 1'b1;
         end
         if (cmd_push && !issue) begin
            cmd_count <= cmd_count + 1'b1;
         end else if (!cmd_push && issue) begin
            cmd_count <= cmd_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RDEPTH; i++) begin
            res_mem[i] <= '0;
         end
         res_wp      <= '0;
         res_rp      <= '0;
         res_count   <= '0;
         outstanding <= '0;
         err_unexp   <= 1'b0;
      end else begin
         if (res_accept) begin
            res_mem[res_wp] <= add_y;
            res_wp          <= res_wp + 1'b1;
         end
         if (res_pop) begin
            res_rp <= res_rp + 1'b1;
         end
         if (res_accept && !res_pop) begin
            res_count <= res_count + 1'b1;
         end else if (!res_accept && res_pop) begin
            res_count <= res_count - 1'b1;
         end
         if (issue && !res_accept) begin
            outstanding <= outstanding + 1'b1;
         end else if (!issue && res_accept) begin
            outstanding <= outstanding - 1'b1;
         end
         if (unexp) begin
            err_unexp <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_add_req_sequencer.sv
// Directed bench for add_req_sequencer with a two-cycle-latency adder model.
module tb_add_req_sequencer;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         add_start;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic [W-1:0] add_y;
   logic         add_valid;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_y;
   logic         busy;
   logic         err_unexp;

   int checks = 0;
   int errors = 0;

   logic         model_en  = 1'b0;
   logic         m_valid   = 1'b0;
   logic [W-1:0] m_y       = '0;
   logic         p1_v      = 1'b0;
   logic [W-1:0] p1_y      = '0;
   logic         man_valid = 1'b0;
   logic [W-1:0] man_y     = '0;

   int start_cnt = 0;
   int pop_cnt   = 0;
   int credit_viol = 0;

   assign add_valid = model_en ? m_valid : man_valid;
   assign add_y     = model_en ? m_y     : man_y;

   add_req_sequencer #(.W(W), .CDEPTH(4), .RDEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .add_start(add_start), .add_a(add_a), .add_b(add_b),
      .add_y(add_y), .add_valid(add_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .busy(busy), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   // Adder model: result presented two cycles after the add_start pulse.
   always @(negedge clk) begin
      m_valid = p1_v;
      m_y     = p1_y;
      p1_v    = model_en & add_start;
      p1_y    = add_a + add_b;
      if (add_start) start_cnt++;
      if (rst_n && (start_cnt - pop_cnt > 4)) credit_viol++;
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) pop_cnt++;
   end

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      bit done = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 50 && !done; i++) begin
         if (in_ready) done = 1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL push_timeout: in_ready stayed 0 for a=%h b=%h", a, b);
      end
   endtask

   task automatic pop_expect(input logic [W-1:0] exp, input string name);
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: out_valid never rose, required out_y=%h", name, exp);
      end else if (out_y !== exp) begin
         errors++;
         $display("FAIL %s: out_y=%h required %h", name, out_y, exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, add_start, busy, err_unexp} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags: rdy,ov,st,busy,err=%b required 10000",
                  {in_ready, out_valid, add_start, busy, err_unexp});
      end
      checks++;
      if (add_a !== '0 || add_b !== '0) begin
         errors++;
         $display("FAIL reset_operands: add_a=%h add_b=%h required 000 000", add_a, add_b);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      model_en = 1'b1;
      push(12'h005, 12'h00A);
      checks++;
      if (add_start !== 1'b0) begin
         errors++;
         $display("FAIL single_latency: add_start=%b one cycle after accept, required 0", add_start);
      end
      @(negedge clk);
      checks++;
      if (add_start !== 1'b1 || add_a !== 12'h005 || add_b !== 12'h00A) begin
         errors++;
         $display("FAIL single_issue: start=%b a=%h b=%h required 1 005 00A", add_start, add_a, add_b);
      end
      @(negedge clk);
      checks++;
      if (add_start !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse: add_start=%b required 0", add_start);
      end
      pop_expect(12'h00F, "single_result");
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_wrap;
      push(12'hFFF, 12'h001);
      push(12'h800, 12'h800);
      pop_expect(12'h000, "wrap_fff_001");
      pop_expect(12'h000, "wrap_800_800");
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_extra: out_valid=%b busy=%b required 0 0", out_valid, busy);
      end
   endtask

   task automatic test_credit;
      int base;
      int got;
      base = start_cnt;
      got  = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(W'(i), W'(i + 1));
      repeat (10) @(negedge clk);
      checks++;
      if (start_cnt - base !== 4) begin
         errors++;
         $display("FAIL credit_starts: %0d add_start pulses required 4", start_cnt - base);
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL credit_full: in_ready=%b out_valid=%b busy=%b required 0 1 1",
                  in_ready, out_valid, busy);
      end
      out_ready = 1'b1;
      for (int t = 0; t < 100 && got < 8; t++) begin
         if (out_valid) begin
            checks++;
            if (out_y !== W'(2 * got + 1)) begin
               errors++;
               $display("FAIL credit_drain[%0d]: out_y=%h required %h", got, out_y, W'(2 * got + 1));
            end
            got++;
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if (got !== 8 || start_cnt - base !== 8) begin
         errors++;
         $display("FAIL credit_count: results=%0d starts=%0d required 8 8", got, start_cnt - base);
      end
      checks++;
      if (credit_viol !== 0) begin
         errors++;
         $display("FAIL credit_limit: %0d cycles over credit required 0", credit_viol);
      end
   endtask

   task automatic test_unexpected;
      model_en = 1'b0;
      man_valid = 1'b1;
      man_y     = 12'h123;
      @(negedge clk);
      man_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (err_unexp !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL unexp_flag: err=%b out_valid=%b busy=%b required 1 0 0",
                  err_unexp, out_valid, busy);
      end
      model_en = 1'b1;
      push(12'h321, 12'h111);
      pop_expect(12'h432, "unexp_next_op");
      checks++;
      if (err_unexp !== 1'b1) begin
         errors++;
         $display("FAIL unexp_sticky: err=%b required 1", err_unexp);
      end
   endtask

   task automatic test_reset_midrun;
      int base;
      bit seen;
      model_en = 1'b1;
      push(12'h001, 12'h002);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      model_en = 1'b0;
      base = start_cnt;
      for (int i = 0; i < 5; i++) push(W'(16 + i), 12'h001);
      repeat (4) @(negedge clk);
      checks++;
      if (start_cnt - base !== 3 || in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_setup: starts=%0d in_ready=%b busy=%b required 3 1 1",
                  start_cnt - base, in_ready, busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if ({in_ready, out_valid, add_start, busy, err_unexp} !== 5'b10000) begin
         errors++;
         $display("FAIL midrun_cleared: rdy,ov,st,busy,err=%b required 10000",
                  {in_ready, out_valid, add_start, busy, err_unexp});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (add_start !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_reissue: add_start=%b busy=%b required 0 0", add_start, busy);
      end
      man_valid = 1'b1;
      man_y     = 12'h055;
      @(negedge clk);
      man_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (err_unexp !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrun_unexp: err=%b out_valid=%b required 1 0", err_unexp, out_valid);
      end
      model_en = 1'b1;
      push(12'h100, 12'h023);
      push(12'h7FF, 12'h001);
      pop_expect(12'h123, "midrun_fresh0");
      pop_expect(12'h800, "midrun_fresh1");
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset;
      test_single;
      test_wrap;
      test_credit;
      test_unexpected;
      test_reset_midrun;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
